// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions and sequencer state encoding for the ALU execute stage.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 5;
  localparam int unsigned FLAGS_W    = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 5'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 5'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 5'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_MOV = 5'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 5'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 5'd10;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 5'd11;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOT = 5'd12;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  // True for every opcode the execute stage implements
  function automatic logic is_legal(input logic [ALU_CTRL_W-1:0] ctrl);
    logic legal;
    legal = 1'b0;
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_MUL, ALU_MOV,
      ALU_AND, ALU_OR, ALU_XOR, ALU_NOT: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU: add/sub with carry/overflow, logic ops, move.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]      srcA,
  input  logic [WIDTH-1:0]      srcB,
  output logic [WIDTH-1:0]      result,
  output logic [FLAGS_W-1:0]    alu_flags
);

  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;

  // Shared adder: SUB is A + ~B + 1, so C means "no borrow"
  always_comb begin
    cin  = (alu_ctrl == ALU_SUB);
    b_op = cin ? ~srcB : srcB;
    sum  = {1'b0, srcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
  end

  // Opcode decode and flag generation
  always_comb begin
    result    = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    alu_flags = '0;
    case (alu_ctrl)
      ALU_ADD, ALU_SUB: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (srcA[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
      end
      ALU_MOV: result = srcA;
      ALU_AND: result = srcA & srcB;
      ALU_OR:  result = srcA | srcB;
      ALU_XOR: result = srcA ^ srcB;
      ALU_NOT: result = ~srcA;
      default: result = '0;
    endcase
    alu_flags[FLAG_N] = result[WIDTH-1];
    alu_flags[FLAG_Z] = (result == '0);
    alu_flags[FLAG_C] = carry;
    alu_flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier consuming BITS multiplier bits per step.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BITS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_c,
  output logic [2*WIDTH-1:0] prod_c
);

  localparam int unsigned STEPS = WIDTH / BITS;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_d;

  // Partial product of the low BITS multiplier bits against the shifted multiplicand
  always_comb begin
    pp = '0;
    for (int unsigned k = 0; k < BITS; k++) begin
      if (mplier_q[k]) pp = pp + (mcand_q << k);
    end
    acc_d = acc_q + pp;
  end

  // The final step's sum is offered combinationally so the caller can register it
  assign done_c = busy_q && (cnt_q == '0);
  assign prod_c = acc_d;

  // Operand latch on start, then one shift-add step per clock until the count expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(STEPS - 1);
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << BITS;
      mplier_q <= mplier_q >> BITS;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (done_c) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Execute-stage responder: valid/ready request in, registered result/flags out.
// Single-cycle ops go through the combinational alu; MUL runs on alu_mul_iter.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned CTRL_W             = 5,
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CTRL_W-1:0] req_ctrl,
  input  logic [WIDTH-1:0]  req_src_a,
  input  logic [WIDTH-1:0]  req_src_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err
);

  state_t                  state_q;
  logic                    rsp_valid_q;
  logic [WIDTH-1:0]        rsp_result_q;
  logic [FLAGS_W-1:0]      rsp_flags_q;
  logic                    rsp_err_q;

  logic [ALU_CTRL_W-1:0]   ctrl;
  logic                    accept;
  logic                    op_is_mul;
  logic                    op_legal;
  logic [WIDTH-1:0]        alu_result;
  logic [FLAGS_W-1:0]      alu_flags;
  logic                    mul_done;
  logic [2*WIDTH-1:0]      mul_prod;
  logic [FLAGS_W-1:0]      mul_flags;

  assign ctrl      = ALU_CTRL_W'(req_ctrl);
  assign op_is_mul = (ctrl == ALU_MUL);
  assign op_legal  = is_legal(ctrl);

  // A drained or draining response slot can take a new request in the same cycle
  assign req_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
  assign accept    = req_valid & req_ready;

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .alu_ctrl (ctrl),
    .srcA     (req_src_a),
    .srcB     (req_src_b),
    .result   (alu_result),
    .alu_flags(alu_flags)
  );

  alu_mul_iter #(
    .WIDTH(WIDTH),
    .BITS (MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(accept & op_is_mul),
    .a_i    (req_src_a),
    .b_i    (req_src_b),
    .done_c (mul_done),
    .prod_c (mul_prod)
  );

  // MUL flags: V reports a non-zero upper half of the full product
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mul_flags[FLAG_C] = 1'b0;
    mul_flags[FLAG_V] = |mul_prod[2*WIDTH-1:WIDTH];
  end

  // Sequencer state and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            if (op_is_mul) begin
              state_q     <= MUL;
              rsp_valid_q <= 1'b0;
            end else if (op_legal) begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_result_q <= alu_result;
              rsp_flags_q  <= alu_flags;
              rsp_err_q    <= 1'b0;
            end else begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_result_q <= '0;
              rsp_flags_q  <= '0;
              rsp_err_q    <= 1'b1;
            end
          end else if ((state_q == RESP) && rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= mul_prod[WIDTH-1:0];
            rsp_flags_q  <= mul_flags;
            rsp_err_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

endmodule
